// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, conv kernel, FC weight function and frame sizes for cnn_top
package cnn_pkg;
  localparam int IMG_W = 28;
  localparam int PIX_W = 8;
  localparam int WI = 8;
  localparam int BW = 32;
  localparam int ACCW = 32;
  localparam int In_d_W = 32;
  localparam int W = IMG_W - 2;
  localparam int FEAT_W_FC = In_d_W;
  localparam int WGT_W_FC = 8;
  localparam int ACC_W_FC = FEAT_W_FC + WGT_W_FC + 12;
  localparam int NPIX = IMG_W * IMG_W;
  localparam int NFEAT = W * W;
  localparam logic signed [WI-1:0] K [3][3] = '{'{-1, -1, -1}, '{-1, 8, -1}, '{-1, -1, -1}};
  localparam logic signed [BW-1:0] CONV_BIAS = '0;
  function automatic logic signed [WGT_W_FC-1:0] wfc(input int k);
    return WGT_W_FC'(((k * 7 + 3) % 17) - 8);
  endfunction
endpackage

// File: rtl/cnn_conv3x3_linebuf.sv
// conv3x3_linebuf: pixel counters, line buffers, 3x3 window and conv MAC with optional ReLU (CNN_CONV_RELU_EN)
import cnn_pkg::*;
module conv3x3_linebuf (
  input  logic                     iClk,
  input  logic                     iRsn,
  input  logic [PIX_W-1:0]         iPixelIn,
  input  logic                     iPixelValid,
  output logic signed [In_d_W-1:0] oFeature,
  output logic                     oFeatValid
);
  localparam int CW = $clog2(IMG_W);
  logic [CW-1:0] r_row, r_col;
  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_win [3][3];
  logic r_fire;
  logic signed [In_d_W-1:0] r_feat;
  logic r_feat_valid;
  logic signed [ACCW-1:0] w_sum;
  logic signed [In_d_W-1:0] w_feat;
  logic w_last_col, w_last_row;
  always_comb begin
    w_last_col = r_col == CW'(IMG_W - 1);
    w_last_row = r_row == CW'(IMG_W - 1);
    w_sum = ACCW'(CONV_BIAS);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w_sum += ACCW'(K[i][j]) * ACCW'($signed({1'b0, r_win[i][j]}));
`ifdef CNN_CONV_RELU_EN
    w_feat = w_sum[ACCW-1] ? '0 : In_d_W'(w_sum);
`else
    w_feat = In_d_W'(w_sum);
`endif
  end
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_row <= '0;
      r_col <= '0;
      r_fire <= 1'b0;
      r_feat <= '0;
      r_feat_valid <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= '0;
    end else begin
      r_fire <= iPixelValid && r_row >= CW'(2) && r_col >= CW'(2);
      r_feat_valid <= r_fire;
      if (r_fire) r_feat <= w_feat;
      if (iPixelValid) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= r_lb1[r_col];
        r_win[1][2] <= r_lb0[r_col];
        r_win[2][2] <= iPixelIn;
        r_lb1[r_col] <= r_lb0[r_col];
        r_lb0[r_col] <= iPixelIn;
        r_col <= w_last_col ? '0 : r_col + 1'b1;
        if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
      end
    end
  end
  assign oFeature = r_feat;
  assign oFeatValid = r_feat_valid;
endmodule

// File: rtl/cnn_top.sv
// cnn_top: 28x28 stream classifier, conv3x3 -> optional ReLU (CNN_CONV_RELU_EN) -> FC dot product to one logit
import cnn_pkg::*;
module cnn_top (
  input  logic                       iClk,
  input  logic                       iRsn,
  input  logic [PIX_W-1:0]           iPixelIn,
  input  logic                       iPixelValid,
  output logic                       oLogitValid,
  output logic signed [ACC_W_FC-1:0] oLogit,
  output logic                       oClass
);
  localparam int KW = $clog2(NFEAT);
  logic signed [In_d_W-1:0] w_feat;
  logic w_feat_valid;
  logic [KW-1:0] r_k;
  logic signed [ACC_W_FC-1:0] r_acc, r_logit, w_acc;
  logic r_valid, r_class, w_last;
  conv3x3_linebuf u_conv (
    .iClk(iClk),
    .iRsn(iRsn),
    .iPixelIn(iPixelIn),
    .iPixelValid(iPixelValid),
    .oFeature(w_feat),
    .oFeatValid(w_feat_valid)
  );
  always_comb begin
    w_last = r_k == KW'(NFEAT - 1);
    w_acc = (r_k == '0 ? ACC_W_FC'(0) : r_acc) + ACC_W_FC'(w_feat) * ACC_W_FC'(wfc(int'(r_k)));
  end
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_k <= '0;
      r_acc <= '0;
      r_logit <= '0;
      r_class <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_feat_valid && w_last;
      if (w_feat_valid) begin
        r_acc <= w_acc;
        r_k <= w_last ? '0 : r_k + 1'b1;
        if (w_last) begin
          r_logit <= w_acc;
          r_class <= !w_acc[ACC_W_FC-1] && |w_acc;
        end
      end
    end
  end
  assign oLogitValid = r_valid;
  assign oLogit = r_logit;
  assign oClass = r_class;
endmodule

// File: tb/tb_cnn_top.sv
// tb_cnn_top: scoreboard bench for cnn_top, expectations track CNN_CONV_RELU_EN
module tb_cnn_top;
  import cnn_pkg::*;
`ifdef CNN_CONV_RELU_EN
  localparam longint EXP_PT = 240;
  localparam longint EXP_CORNER = 0;
`else
  localparam longint EXP_PT = 170;
  localparam longint EXP_CORNER = 17;
`endif
  logic iClk = 1'b0;
  logic iRsn = 1'b0;
  logic [PIX_W-1:0] iPixelIn = '0;
  logic iPixelValid = 1'b0;
  logic oLogitValid;
  logic signed [ACC_W_FC-1:0] oLogit;
  logic oClass;
  typedef struct {
    longint logit;
    logic   cls;
    int     at;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [PIX_W-1:0] img [NPIX];
  cnn_top dut (
    .iClk(iClk),
    .iRsn(iRsn),
    .iPixelIn(iPixelIn),
    .iPixelValid(iPixelValid),
    .oLogitValid(oLogitValid),
    .oLogit(oLogit),
    .oClass(oClass)
  );
  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc++;
  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic fill(input logic [PIX_W-1:0] v);
    for (int p = 0; p < NPIX; p++) img[p] = v;
  endtask
  task automatic idle(input int n);
    iPixelValid = 1'b0;
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask
  task automatic drive_frame(input int n, input longint exp_logit, input bit gaps);
    for (int p = 0; p < n; p++) begin
      if (gaps) idle($urandom_range(0, 2));
      iPixelIn = img[p];
      iPixelValid = 1'b1;
      if (p == NPIX - 1) q.push_back('{exp_logit, exp_logit > 0, cyc + 3});
      @(posedge iClk);
      #1;
    end
    iPixelValid = 1'b0;
  endtask
  always @(negedge iClk) begin
    if (oLogitValid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pulse: logit %0d at edge %0d, no pulse expected", oLogit, cyc);
      end else begin
        e = q.pop_front();
        check("logit", longint'(oLogit), e.logit);
        check("class", longint'(oClass), longint'(e.cls));
        check("pulse_edge", cyc, e.at);
      end
    end
  end
  initial begin
    fill('0);
    repeat (3) @(posedge iClk);
    #1;
    check("rst_valid", longint'(oLogitValid), 0);
    check("rst_logit", longint'(oLogit), 0);
    check("rst_class", longint'(oClass), 0);
    iRsn = 1'b1;
    idle(2);
    drive_frame(NPIX, 0, 1'b0);
    idle(3);
    fill(8'h80);
    drive_frame(NPIX, 0, 1'b0);
    idle(3);
    fill('0);
    img[0] = 8'd1;
    img[NPIX-1] = 8'd2;
    drive_frame(NPIX, EXP_CORNER, 1'b0);
    idle(3);
    fill('0);
    img[5*IMG_W+5] = 8'd10;
    repeat (4) begin
      drive_frame(NPIX, EXP_PT, 1'b0);
      idle(2);
    end
    drive_frame(NPIX, EXP_PT, 1'b1);
    idle(5);
    drive_frame(400, EXP_PT, 1'b0);
    iRsn = 1'b0;
    #1;
    check("abort_rst_logit", longint'(oLogit), 0);
    check("abort_rst_class", longint'(oClass), 0);
    idle(2);
    iRsn = 1'b1;
    idle(2);
    drive_frame(NPIX, EXP_PT, 1'b0);
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    idle(5);
    check("pending_pulses", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cnn_top.md
Name: cnn_top

Overview:
- Single-channel binary MNIST-style classifier.
- Consumes a raster-order stream of 28x28 unsigned pixels, one pixel per valid cycle.
- Applies one fixed 3x3 stride-1 convolution (26x26 feature map), then optional ReLU, then a fully-connected dot product down to one signed logit.
- Emits a one-cycle logit strobe per frame, plus a class bit.

Parameters:
- IMG_W, 28, input image width and height.
- PIX_W, 8, pixel width (unsigned).
- WI, 8, conv kernel weight width (signed).
- BW, 32, conv bias width (signed).
- ACCW, 32, conv MAC accumulator width (signed).
- In_d_W, 32, conv feature output width (signed).
- W, 26, feature map width and height; must equal IMG_W-2.
- FEAT_W_FC, 32, FC input feature width; equals In_d_W.
- WGT_W_FC, 8, FC weight width (signed).
- ACC_W_FC, 52, FC accumulator and logit width; equals FEAT_W_FC+WGT_W_FC+12.

Ports:
- iClk  in  1  the block's single clock, rising edge.
- iRsn  in  1  reset, asynchronous, active-low.
- iPixelIn  in  PIX_W  pixel value, unsigned.
- iPixelValid  in  1  pixel qualifier; a pixel is accepted on each rising edge where this is high.
- oLogitValid  out  1  one-cycle pulse per completed frame.
- oLogit  out  ACC_W_FC  signed frame logit; held until the next pulse.
- oClass  out  1  1 when oLogit>0, else 0; held with oLogit.

Behaviour:
- Reset: all counters, line buffers, window, accumulator and outputs clear to 0; any partial frame is discarded.
- Pixel counters:
  - row/col advance only on accepted pixels; col wraps at IMG_W-1, and row wraps at IMG_W-1 back to 0,0.
  - Frames may be back-to-back or separated by any number of idle cycles.
  - iPixelValid may drop mid-frame; the stream simply stalls.
- Line buffers and window:
  - Two IMG_W-deep line buffers plus a 3x3 window register.
  - The window for accepted pixel (r,c) covers rows r-2..r and cols c-2..c.
- Conv:
  - Fires when the accepted pixel has r>=2 and c>=2, giving output position (r-2,c-2).
  - Feature = sum(K[i][j]*pix) + CONV_BIAS, with pixels zero-extended to signed and the accumulation done in ACCW bits.
  - K = {{-1,-1,-1},{-1,8,-1},{-1,-1,-1}}; CONV_BIAS = 0. No saturation is needed.
- Pipeline timing, for a pixel accepted at edge N:
  - Window updated at edge N.
  - Feature and feat_valid registered at edge N+1.
  - FC accumulate at edge N+2.
- FC:
  - Index k = out_row*W + out_col, range 0..675.
  - acc += feature*WFC[k], where WFC[k] = ((k*7+3) mod 17) - 8 (range -8..8); FC bias is 0.
  - The accumulator starts from 0 at k=0 of each frame.
- Output:
  - The product for k=675 completes the frame sum; oLogit and oClass load at that same edge (N+2 after pixel 783 is accepted), and oLogitValid is high for exactly that one cycle.
  - Outputs hold otherwise.
- Reset asserted mid-frame: no pulse is produced for that frame; the next full frame is computed from clean state.

Optional Feature:
- Macro CNN_CONV_RELU_EN.
- Defined: features are clamped to max(feature,0) before the FC stage.
- Undefined: signed features pass to the FC stage unchanged.
- Latency is identical either way.

Decomposition:
- Package cnn_pkg holds:
  - width defaults;
  - kernel array K and CONV_BIAS;
  - function wfc(k) returning the signed WGT_W_FC weight;
  - constant NPIX=IMG_W*IMG_W and NFEAT=W*W.
- Sub-module conv3x3_linebuf: pixel counters, line buffers, window, conv MAC and ReLU. It outputs feature and feat_valid.
- Top: FC index counter, accumulator, output registers.

Test Plan:
- All-zero frame -> a single oLogitValid pulse, oLogit=0, oClass=0.
- Constant 0x80 frame -> every conv feature is 0; oLogit=0, oClass=0.
- Single pixel 10 at (5,5), rest 0, with CNN_CONV_RELU_EN defined -> only feature index 108 = 80 survives; WFC[108]=3, so oLogit=240 and oClass=1. The pulse comes 2 edges after pixel 783 is accepted.
- Same frame repeated 4 times with 2 idle cycles between frames -> exactly 4 pulses, each with oLogit=240, oClass=1.
- Same frame with random iPixelValid gaps inside the frame -> identical result; the pulse is still 2 edges after the last accepted pixel.
- Reset pulsed at pixel 400, then a full frame -> no pulse from the aborted frame; the next frame gives oLogit=240.
